// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: MIPS instruction field positions, the NOP word and the IF/ID entry type
package mips_pipe_pkg;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SHAMT_HI = 10, SHAMT_LO = 6;
  localparam int FUNCT_HI = 5, FUNCT_LO = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int JOFF_HI = 25, JOFF_LO = 0;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } if_id_entry_t;
endpackage

// File: rtl/mips_field_decode.sv
// mips_field_decode: slices a MIPS word into its fields; a bubble shows NOP_INSN and all-zero fields
module mips_field_decode
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = NOP
) (
  input  logic        i_valid,
  input  logic [31:0] i_insn,
  output logic [31:0] o_insn,
  output logic [5:0]  o_op,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm16,
  output logic [25:0] o_joff
);
  logic [31:0] w_insn;
  assign w_insn  = i_valid ? i_insn : '0;
  assign o_insn  = i_valid ? i_insn : NOP_INSN;
  assign o_op    = w_insn[OP_HI:OP_LO];
  assign o_rs    = w_insn[RS_HI:RS_LO];
  assign o_rt    = w_insn[RT_HI:RT_LO];
  assign o_rd    = w_insn[RD_HI:RD_LO];
  assign o_shamt = w_insn[SHAMT_HI:SHAMT_LO];
  assign o_funct = w_insn[FUNCT_HI:FUNCT_LO];
  assign o_imm16 = w_insn[IMM_HI:IMM_LO];
  assign o_joff  = w_insn[JOFF_HI:JOFF_LO];
endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID register with valid/ready, 2-entry skid buffer, flush bubbles,
// field decode and saturating stall/flush counters.
module if_id_skid_reg
  import mips_pipe_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter int          INSN_W   = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_INSN = NOP
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INSN_W-1:0] insn_in,
  input  logic              if_valid_in,
  output logic              if_ready_out,
  input  logic              id_ready_in,
  output logic              id_valid_out,
  input  logic              flush_jump,
  input  logic              flush_branch,
  output logic [PC_W-1:0]   pc_out,
  output logic [INSN_W-1:0] insn_out,
  output logic [5:0]        op_code_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic [4:0]        shamt_out,
  output logic [5:0]        funct_out,
  output logic [15:0]       imm16_out,
  output logic [25:0]       jump_off_out,
  output logic [CNT_W-1:0]  stall_cnt_out,
  output logic [CNT_W-1:0]  flush_cnt_out
);
  if (INSN_W != 32) begin : g_bad_insn_w
    $error("if_id_skid_reg: field decode requires INSN_W == 32");
  end
  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } entry_t;
  entry_t           r_m, r_s;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_flush, w_acc, w_cons, w_stall;
  assign w_flush       = flush_jump | flush_branch;
  assign if_ready_out  = !r_s.valid;
  assign id_valid_out  = r_m.valid;
  assign w_acc         = if_valid_in & if_ready_out;
  assign w_cons        = r_m.valid & id_ready_in;
  assign w_stall       = r_m.valid & !id_ready_in & !w_flush;
  assign pc_out        = r_m.pc;
  assign stall_cnt_out = r_stall_cnt;
  assign flush_cnt_out = r_flush_cnt;
  // S only fills while M is held, so M never goes empty with S still valid
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_m <= '0;
      r_s <= '0;
    end else if (w_flush) begin
      r_m.valid <= 1'b0;
      r_s.valid <= 1'b0;
    end else if (!r_m.valid || w_cons) begin
      if (r_s.valid) begin
        r_m       <= r_s;
        r_s.valid <= 1'b0;
      end else if (w_acc) r_m <= {1'b1, pc_in, insn_in};
      else r_m.valid <= 1'b0;
    end else if (w_acc) r_s <= {1'b1, pc_in, insn_in};
  end
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  mips_field_decode #(.NOP_INSN(NOP_INSN)) u_dec (
    .i_valid (r_m.valid),
    .i_insn  (r_m.insn),
    .o_insn  (insn_out),
    .o_op    (op_code_out),
    .o_rs    (rs_out),
    .o_rt    (rt_out),
    .o_rd    (rd_out),
    .o_shamt (shamt_out),
    .o_funct (funct_out),
    .o_imm16 (imm16_out),
    .o_joff  (jump_off_out)
  );
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: scoreboard bench; an abstract 2-deep queue model predicts beats and counters
module tb_if_id_skid_reg;
  logic        clk, reset_in;
  logic [31:0] pc, insn;
  logic        v, rdy, fj, fb;
  logic        if_ready_out, id_valid_out;
  logic [31:0] pc_out, insn_out;
  logic [5:0]  op_code_out, funct_out;
  logic [4:0]  rs_out, rt_out, rd_out, shamt_out;
  logic [15:0] imm16_out;
  logic [25:0] jump_off_out;
  logic [3:0]  stall_cnt_out, flush_cnt_out;
  logic [63:0] q[$];
  logic [31:0] last_pc;
  logic [3:0]  e_st, e_fl;
  int          total, bad;

  if_id_skid_reg #(.CNT_W(4)) dut (
    .clk(clk), .reset_in(reset_in), .pc_in(pc), .insn_in(insn),
    .if_valid_in(v), .if_ready_out(if_ready_out), .id_ready_in(rdy),
    .id_valid_out(id_valid_out), .flush_jump(fj), .flush_branch(fb),
    .pc_out(pc_out), .insn_out(insn_out), .op_code_out(op_code_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .shamt_out(shamt_out),
    .funct_out(funct_out), .imm16_out(imm16_out), .jump_off_out(jump_off_out),
    .stall_cnt_out(stall_cnt_out), .flush_cnt_out(flush_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out();
    logic [31:0] ei, ep;
    ei = q.size() != 0 ? q[0][31:0] : 32'h0;
    ep = q.size() != 0 ? q[0][63:32] : last_pc;
    chk("vld", {31'b0, id_valid_out}, {31'b0, q.size() != 0});
    chk("rdy", {31'b0, if_ready_out}, {31'b0, q.size() < 2});
    chk("pc", pc_out, ep);
    chk("insn", insn_out, ei);
    chk("op", {26'b0, op_code_out}, {26'b0, ei[31:26]});
    chk("rs", {27'b0, rs_out}, {27'b0, ei[25:21]});
    chk("rt", {27'b0, rt_out}, {27'b0, ei[20:16]});
    chk("rd", {27'b0, rd_out}, {27'b0, ei[15:11]});
    chk("shamt", {27'b0, shamt_out}, {27'b0, ei[10:6]});
    chk("funct", {26'b0, funct_out}, {26'b0, ei[5:0]});
    chk("imm", {16'b0, imm16_out}, {16'b0, ei[15:0]});
    chk("joff", {6'b0, jump_off_out}, {6'b0, ei[25:0]});
    chk("stall_cnt", {28'b0, stall_cnt_out}, {28'b0, e_st});
    chk("flush_cnt", {28'b0, flush_cnt_out}, {28'b0, e_fl});
    last_pc = ep;
  endtask

  task automatic cyc();
    bit fl, cons, acc;
    @(posedge clk);
    fl   = fj | fb;
    cons = q.size() != 0 && rdy;
    acc  = v && q.size() < 2;
    if (fl) begin
      q.delete();
      if (e_fl != 4'hF) e_fl++;
    end else begin
      if (q.size() != 0 && !rdy && e_st != 4'hF) e_st++;
      if (cons) void'(q.pop_front());
      if (acc) q.push_back({pc, insn});
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic drive(input logic iv, input logic [31:0] ipc, input logic [31:0] iinsn, input logic irdy);
    v = iv; pc = ipc; insn = iinsn; rdy = irdy;
  endtask

  initial begin
    total = 0; bad = 0; last_pc = 0; e_st = 0; e_fl = 0;
    reset_in = 1'b0; fj = 0; fb = 0;
    drive(0, 0, 0, 1);
    #3 check_out();
    @(negedge clk); @(negedge clk);
    reset_in = 1'b1;
    cyc();
    // streaming
    drive(1, 32'h100, 32'h012A4020, 1); cyc();
    chk("s1_op", {26'b0, op_code_out}, 32'h0);
    chk("s1_rs", {27'b0, rs_out}, 32'd9);
    chk("s1_rt", {27'b0, rt_out}, 32'd10);
    chk("s1_rd", {27'b0, rd_out}, 32'd8);
    chk("s1_funct", {26'b0, funct_out}, 32'h20);
    drive(1, 32'h104, 32'h8D090004, 1); cyc();
    chk("s2_op", {26'b0, op_code_out}, 32'h23);
    chk("s2_imm", {16'b0, imm16_out}, 32'h4);
    drive(0, 0, 0, 1); cyc();
    // stall into the skid entry
    drive(1, 32'h200, 32'h20080001, 0); cyc();
    drive(1, 32'h204, 32'h20080002, 0); cyc();
    chk("skid_full", {31'b0, if_ready_out}, 32'h0);
    drive(1, 32'h208, 32'h20080003, 0); cyc();
    cyc();
    chk("stall3", {28'b0, stall_cnt_out}, 32'd3);
    rdy = 1; cyc(); cyc();
    chk("skid_pc3", pc_out, 32'h208);
    drive(0, 0, 0, 1); cyc();
    // flush with both entries full
    drive(1, 32'h2F0, 32'h0000_0020, 0); cyc();
    drive(1, 32'h2F4, 32'h0000_0022, 0); cyc();
    drive(1, 32'h300, 32'h0000_0024, 0); fb = 1; cyc();
    fb = 0;
    chk("fl_vld", {31'b0, id_valid_out}, 32'h0);
    chk("fl_insn", insn_out, 32'h0);
    chk("fl_cnt1", {28'b0, flush_cnt_out}, 32'd1);
    drive(1, 32'h400, 32'h3C01ABCD, 1); cyc();
    chk("post_fl_pc", pc_out, 32'h400);
    drive(0, 0, 0, 1); cyc();
    // simultaneous flushes while consuming, offered beat dropped
    drive(1, 32'h500, 32'h012A4020, 1); cyc();
    drive(1, 32'h504, 32'h8D090004, 1); fj = 1; fb = 1; cyc();
    fj = 0; fb = 0;
    chk("fl_cnt2", {28'b0, flush_cnt_out}, 32'd2);
    chk("st_keep", {28'b0, stall_cnt_out}, 32'd4);
    drive(0, 0, 0, 1); cyc();
    // stall counter saturation
    drive(1, 32'h600, 32'h11111111, 0); cyc();
    drive(1, 32'h604, 32'h22222222, 0); cyc();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 19; i++) cyc();
    chk("sat", {28'b0, stall_cnt_out}, 32'hF);
    // asynchronous reset with both entries valid
    #2 reset_in = 1'b0;
    #1;
    q.delete(); e_st = 0; e_fl = 0; last_pc = 0;
    check_out();
    @(negedge clk);
    reset_in = 1'b1;
    drive(0, 0, 0, 1); cyc();
    drive(1, 32'h700, 32'hAC0A0010, 1); cyc();
    chk("post_rst_pc", pc_out, 32'h700);
    drive(0, 0, 0, 1); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline register for the 32-bit MIPS pipeline, sitting between the fetch stage (PC plus instruction memory) and the decode stage (register file read, hazard unit).
- Adds over the previous IF/ID latch:
  - valid/ready handshaking on both sides,
  - a 2-entry skid buffer so stalls are absorbed without a combinational ready path,
  - unified jump/branch flush producing true bubbles,
  - registered MIPS field decode,
  - saturating stall/flush performance counters.

Parameters:
- PC_W, 32, width of the PC value carried with the instruction.
- INSN_W, 32, instruction width. Field decode is defined for 32 only; any other value is a configuration error and elaboration must fail.
- CNT_W, 16, width of each performance counter.
- NOP_INSN, 32'h0000_0000, instruction word presented on the outputs during a bubble.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- pc_in  in  PC_W  PC of the fetched instruction.
- insn_in  in  INSN_W  fetched instruction word.
- if_valid_in  in  1  fetch offers a beat.
- if_ready_out  out  1  block can accept a beat this cycle.
- id_ready_in  in  1  decode consumes the presented beat.
- id_valid_out  out  1  decode outputs hold a live instruction.
- flush_jump  in  1  jump-resolved flush.
- flush_branch  in  1  branch-taken flush.
- pc_out  out  PC_W  PC of the presented instruction.
- insn_out  out  INSN_W  presented instruction word.
- op_code_out  out  6  insn[31:26].
- rs_out  out  5  insn[25:21]; read reg 1 and hazard Rs.
- rt_out  out  5  insn[20:16]; read reg 2 and hazard Rt.
- rd_out  out  5  insn[15:11].
- shamt_out  out  5  insn[10:6].
- funct_out  out  6  insn[5:0].
- imm16_out  out  16  insn[15:0]; feeds the sign extender.
- jump_off_out  out  26  insn[25:0].
- stall_cnt_out  out  CNT_W  cycles with id_valid_out=1 and id_ready_in=0.
- flush_cnt_out  out  CNT_W  cycles with any flush asserted.

Behaviour:
- Reset (reset_in=0, asynchronous), regardless of clk:
  - both entry valids = 0; all PC and instruction storage = 0; both counters = 0.
  - if_ready_out = 1.
  - id_valid_out = 0 and every decoded field = 0.
- Storage: main entry M drives the outputs; skid entry S holds overflow. Each entry is {valid, pc, insn}.
- if_ready_out = !S.valid. It is driven from a register and never depends combinationally on id_ready_in.
- Accept = if_valid_in & if_ready_out. Consume = id_valid_out & id_ready_in.
- Normal cycle (no flush):
  - M empty, or M consumed: M loads from S if S is valid (S clears), else from the accepted beat, else M.valid <= 0.
  - M valid, M consumed, S valid, and a beat accepted: not possible, because if_ready_out = 0 whenever S is valid.
  - M valid and not consumed: an accepted beat goes to S.
- Latency: an accepted beat with M empty appears on the outputs the next cycle. Throughput is 1 beat per cycle when id_ready_in=1.
- Flush (flush_jump | flush_branch):
  - M.valid <= 0 and S.valid <= 0.
  - Any beat offered in the flush cycle is dropped.
  - Flush overrides accept and consume.
  - The first post-flush beat is accepted the following cycle.
- Bubble (M.valid=0): insn_out = NOP_INSN; all decoded fields = 0; pc_out holds its last value.
- Decoded fields are slices of M.insn, valid in the same cycle as id_valid_out. They are not a further register stage.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones (no wrap). A flush cycle counts as a flush only, never as a stall.
- Reset asserted mid-stream clears everything immediately. Release is synchronous to the next clk edge; no beat is accepted on the release edge.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - field bit-position constants (OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO, JOFF_HI/LO),
  - NOP constant,
  - a packed if_id_entry_t typedef {valid, pc, insn}.
- One sub-module, mips_field_decode: combinational slicing plus bubble zeroing, to be reused by the later ID/EX register.
- The counters are inline.

Test Plan:
- Reset mid-stream: assert reset_in=0 while M and S are valid -> same cycle, id_valid_out=0, all fields 0, counters 0, if_ready_out=1.
- Streaming: id_ready_in=1; feed insn 0x012A4020 (add $8,$9,$10) at pc 0x100, then 0x8D090004 at pc 0x104 -> each appears one cycle later:
  - first: op=0, rs=9, rt=10, rd=8, funct=0x20.
  - second: op=0x23, imm16=0x0004.
- Stall/skid: hold id_ready_in=0 for 3 cycles while offering beats at pc 0x200, 0x204, 0x208 -> 0x200 and 0x204 accepted; if_ready_out=0 after the second accept; 0x208 held by fetch; stall_cnt_out=3; on release, outputs 0x200, 0x204, 0x208 in order with no loss or duplication.
- Flush with full skid: M and S valid, pulse flush_branch for one cycle with a beat at pc 0x300 offered -> next cycle id_valid_out=0 and insn_out=0; 0x300 dropped; flush_cnt_out=1; the following beat at 0x400 passes normally.
- Simultaneous flush_jump and flush_branch together with consume -> single flush; flush_cnt_out +1; stall_cnt_out unchanged.
- Counter saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cnt_out stops at 4'hF.
